// File: rtl/wb_test_mailbox.sv
// Wishbone test mailbox: the test program writes its result and end flag here.
// A watchdog counter and result comparison raise done/pass/timeout for the bench.
module wb_test_mailbox #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
   parameter int          TIMEOUT   = 600,
   parameter int          ACK_DELAY = 1,
   parameter int          CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_start,
   input  logic [31:0]      i_expected,
   input  logic             i_wb_we,
   input  logic [3:0]       i_wb_sel,
   input  logic [31:0]      i_wb_adr,
   input  logic [31:0]      i_wb_dat,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   output logic [31:0]      o_wb_dat,
   output logic             o_wb_ack,
   output logic             o_hit,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_timeout,
   output logic [31:0]      o_result,
   output logic [CNT_W-1:0] o_cycles
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE, ST_TIMEOUT} state_t;

   localparam logic [2:0]       ACK_D   = 3'(ACK_DELAY);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int n = 0; n < 4; n++)
         if (be[n]) r[8*n +: 8] = wdat[8*n +: 8];
      return r;
   endfunction

   state_t            state, state_nxt;
   logic              vld_p0;
   logic [2:0]        dly_p0;
   logic [1:0]        off_p0;
   logic              we_p0;
   logic [3:0]        sel_p0;
   logic [31:0]       dat_p0;
   logic [31:0]       result, result_nxt;
   logic [CNT_W-1:0]  cycles;
   logic              pass;
   logic              accept, ack, wr, valid_wr, abort;
   logic              unused_adr;

   assign unused_adr = ^i_wb_adr[1:0];

   always_comb begin
      o_hit      = i_wb_cyc & i_wb_stb & (i_wb_adr[31:4] == BASE_ADDR[31:4]);
      accept     = o_hit & ~vld_p0 & ~i_start;
      ack        = vld_p0 & (dly_p0 == ACK_D) & i_wb_cyc & i_wb_stb & ~i_start;
      abort      = vld_p0 & ~(i_wb_cyc & i_wb_stb);
      wr         = ack & we_p0;
      valid_wr   = wr & (off_p0 == 2'd0) & sel_p0[0] & dat_p0[0];
      result_nxt = (wr && off_p0 == 2'd1) ? byte_merge(result, dat_p0, sel_p0) : result;
   end

   // Stage p0: accepted request held until ack, abort or arm
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         vld_p0 <= 1'b0;
         dly_p0 <= '0;
         off_p0 <= '0;
         we_p0  <= 1'b0;
         sel_p0 <= '0;
         dat_p0 <= '0;
      end else if (i_start || ack || abort) begin
         vld_p0 <= 1'b0;
         dly_p0 <= '0;
      end else if (accept) begin
         vld_p0 <= 1'b1;
         dly_p0 <= 3'd1;
         off_p0 <= i_wb_adr[3:2];
         we_p0  <= i_wb_we;
         sel_p0 <= i_wb_sel;
         dat_p0 <= i_wb_dat;
      end else if (vld_p0) begin
         dly_p0 <= dly_p0 + 3'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARMED: begin
            if (valid_wr)              state_nxt = ST_DONE;
            else if (cycles == TO_LAST) state_nxt = ST_TIMEOUT;
         end
         default: state_nxt = state;
      endcase
      if (i_start) state_nxt = ST_ARMED;
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state  <= ST_IDLE;
         result <= '0;
         cycles <= '0;
         pass   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (i_start) begin
            result <= '0;
            cycles <= '0;
            pass   <= 1'b0;
         end else begin
            result <= result_nxt;
            // The VALID write wins over a coincident timeout and freezes the counter
            if (state == ST_ARMED) begin
               if (valid_wr)               pass   <= (result_nxt == i_expected);
               else if (cycles == TO_LAST) cycles <= TO_VAL;
               else                        cycles <= cycles + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      o_wb_dat = '0;
      if (ack && !we_p0) begin
         case (off_p0)
            2'd1:    o_wb_dat = result;
            2'd2:    o_wb_dat = {29'b0, state == ST_TIMEOUT, pass, state == ST_DONE};
            2'd3:    o_wb_dat = 32'(cycles);
            default: o_wb_dat = '0;
         endcase
      end
      o_wb_ack  = ack;
      o_done    = (state == ST_DONE);
      o_pass    = pass;
      o_timeout = (state == ST_TIMEOUT);
      o_result  = result;
      o_cycles  = cycles;
   end

endmodule

// File: tb/tb_wb_test_mailbox.sv
// Directed bench for wb_test_mailbox: one instance with ACK_DELAY=1 at 0x500,
// one with ACK_DELAY=3 at 0x600 sharing the same bus.
module tb_wb_test_mailbox;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] expected = '0;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0;
   logic [31:0] dat = '0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;

   logic [31:0] dat1, dat3, res1, res3;
   logic        ack1, ack3, hit1, hit3, done1, done3, pass1, pass3, to1, to3;
   logic [15:0] cyc1, cyc3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_test_mailbox #(.BASE_ADDR(32'h0000_0500), .TIMEOUT(600), .ACK_DELAY(1), .CNT_W(16)) dut1 (
      .i_clk(clk), .i_arst(arst), .i_start(start), .i_expected(expected),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(dat),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_dat(dat1), .o_wb_ack(ack1), .o_hit(hit1),
      .o_done(done1), .o_pass(pass1), .o_timeout(to1), .o_result(res1), .o_cycles(cyc1));

   wb_test_mailbox #(.BASE_ADDR(32'h0000_0600), .TIMEOUT(600), .ACK_DELAY(3), .CNT_W(16)) dut3 (
      .i_clk(clk), .i_arst(arst), .i_start(start), .i_expected(expected),
      .i_wb_we(we), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(dat),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_dat(dat3), .o_wb_ack(ack3), .o_hit(hit3),
      .o_done(done3), .o_pass(pass3), .o_timeout(to3), .o_result(res3), .o_cycles(cyc3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // lat counts negedges from the request cycle (1) to the ack cycle
   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output logic leak);
      rd = '0; lat = 0; leak = 1'b0;
      @(posedge clk); #1;
      we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (!(ack1 | ack3) && ((dat1 | dat3) != 32'd0)) leak = 1'b1;
      end while (!(ack1 | ack3) && lat < 20);
      check("ack_seen", 32'(ack1 | ack3), 32'd1);
      rd = ack1 ? dat1 : dat3;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd; int lat; logic leak;
      bus(1'b1, a, d, s, rd, lat, leak);
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd);
      int lat; logic leak;
      bus(1'b0, a, 32'd0, 4'hf, rd, lat, leak);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      logic        leak;
      logic [15:0] snap;
      logic        seen;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", 32'(done1), 0);
      check("rst_pass", 32'(pass1), 0);
      check("rst_timeout", 32'(to1), 0);
      check("rst_result", res1, 0);
      check("rst_ack", 32'(ack1), 0);
      @(negedge clk) arst = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("idle_cycles", 32'(cyc1), 0);

      // pass case
      pulse_start();
      expected = 32'd21;
      bus(1'b1, 32'h504, 32'd21, 4'hf, rd, lat, leak);
      check("lat_result_wr", 32'(lat - 1), 32'd1);
      bus(1'b1, 32'h500, 32'd1, 4'hf, rd, lat, leak);
      check("lat_valid_wr", 32'(lat - 1), 32'd1);
      check("t1_done", 32'(done1), 1);
      check("t1_pass", 32'(pass1), 1);
      rd_reg(32'h508, rd);
      check("t1_status", rd, 32'd3);

      // fail case, counter frozen
      pulse_start();
      expected = 32'd8;
      wr(32'h504, 32'd7, 4'hf);
      wr(32'h500, 32'd1, 4'hf);
      check("t2_done", 32'(done1), 1);
      check("t2_pass", 32'(pass1), 0);
      check("t2_timeout", 32'(to1), 0);
      snap = cyc1;
      repeat (5) @(posedge clk);
      #1 check("t2_frozen", 32'(cyc1), 32'(snap));
      rd_reg(32'h50C, rd);
      check("t2_cycles_reg", rd, 32'(snap));

      // watchdog
      pulse_start();
      repeat (599) @(posedge clk);
      #1;
      check("t3_pre_to", 32'(to1), 0);
      check("t3_pre_cyc", 32'(cyc1), 32'd599);
      @(posedge clk); #1;
      check("t3_timeout", 32'(to1), 1);
      check("t3_cycles", 32'(cyc1), 32'd600);
      wr(32'h500, 32'd1, 4'hf);
      check("t3_valid_late", 32'(done1), 0);
      check("t3_hold_cyc", 32'(cyc1), 32'd600);

      // byte enables, read-only and write-only offsets
      wr(32'h504, 32'd0, 4'hf);
      wr(32'h504, 32'h00AB_0000, 4'b0100);
      wr(32'h504, 32'h0000_00CD, 4'b0001);
      rd_reg(32'h504, rd);
      check("t4_bytes", rd, 32'h00AB_00CD);
      rd_reg(32'h500, rd);
      check("t4_valid_rd", rd, 32'd0);
      wr(32'h508, 32'hFFFF_FFFF, 4'hf);
      rd_reg(32'h508, rd);
      check("t4_status_ro", rd, 32'd4);

      // ACK_DELAY=3: full access, then aborted access
      bus(1'b1, 32'h604, 32'h11, 4'hf, rd, lat, leak);
      check("t5_lat3", 32'(lat - 1), 32'd3);
      bus(1'b0, 32'h604, 32'd0, 4'hf, rd, lat, leak);
      check("t5_rd", rd, 32'h11);
      check("t5_no_leak", 32'(leak), 0);
      @(posedge clk); #1;
      we = 1'b1; adr = 32'h604; dat = 32'h99; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1 stb = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack3) seen = 1'b1;
      end
      cyc = 1'b0; we = 1'b0;
      check("t5_abort_ack", 32'(seen), 0);
      check("t5_abort_res", res3, 32'h11);

      // VALID write on the timeout cycle
      expected = 32'd0;
      pulse_start();
      repeat (598) @(posedge clk);
      #1;
      we = 1'b1; adr = 32'h500; dat = 32'd1; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      check("t6_ack", 32'(ack1), 1);
      check("t6_cyc", 32'(cyc1), 32'd599);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("t6_done", 32'(done1), 1);
      check("t6_timeout", 32'(to1), 0);
      check("t6_pass", 32'(pass1), 1);
      wr(32'h504, 32'h1234, 4'hf);
      check("t6_res_done", res1, 32'h1234);
      check("t6_pass_sticky", 32'(pass1), 1);

      // start concurrent with a RESULT write
      @(posedge clk); #1;
      we = 1'b1; adr = 32'h504; dat = 32'h55; sel = 4'hf; cyc = 1'b1; stb = 1'b1; start = 1'b1;
      seen = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ack1) seen = 1'b1;
      end
      check("t7_no_ack", 32'(seen), 0);
      check("t7_result", res1, 0);
      check("t7_done", 32'(done1), 0);
      check("t7_cyc_run", 32'(cyc1 != 16'd0), 1);

      // reset mid-access
      wr(32'h504, 32'h42, 4'hf);
      @(posedge clk); #1;
      we = 1'b1; adr = 32'h504; dat = 32'h77; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1 arst = 1'b1;
      #1 check("t8_ack_rst", 32'(ack1), 0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk);
      @(negedge clk) arst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t8_result", res1, 0);
      check("t8_idle_cyc", 32'(cyc1), 0);
      check("t8_flags", {29'b0, to1, pass1, done1}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_test_mailbox.md
Name: wb_test_mailbox

Overview:
- Wishbone slave on the core's data bus, downstream of the MIPS core and beside the test memory slave.
- A test program writes its result word and an end-of-test flag here.
- The block runs a watchdog cycle counter and compares the result against the bench-supplied expected value.
- It raises done/pass/timeout flags, so benches no longer poll memory contents.

Parameters:
- BASE_ADDR, 32'h0000_0500, byte base address of the 16-byte register window; bits [3:0] must be 0.
- TIMEOUT, 600, clock cycles from arm until timeout.
- ACK_DELAY, 1, cycles from accepted request to o_wb_ack; legal range 1..7.
- CNT_W, 16, width of the cycle counter; TIMEOUT < 2**CNT_W.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_start  in  1  arm pulse; clears the result, flags and counter, and enters ARMED.
- i_expected  in  32  expected result; sampled when VALID is written.
- i_wb_we  in  1  Wishbone write enable.
- i_wb_sel  in  4  byte selects; bit n selects data [8n+7:8n].
- i_wb_adr  in  32  byte address.
- i_wb_dat  in  32  write data.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_dat  out  32  read data; valid only in the ack cycle, 0 otherwise.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_hit  out  1  combinational: cyc & stb & i_wb_adr[31:4]==BASE_ADDR[31:4]; interconnect uses it to steer data and ack.
- o_done  out  1  end flag received while ARMED.
- o_pass  out  1  done and result == expected.
- o_timeout  out  1  watchdog expired.
- o_result  out  32  RESULT register.
- o_cycles  out  CNT_W  cycle counter.

Behaviour:
- Reset: all outputs and registers 0 except o_hit, which stays combinational; state IDLE.
- Register map, word offset i_wb_adr[3:2]:
  - 0 VALID: write only; reads return 0.
  - 1 RESULT: read/write with byte enables.
  - 2 STATUS: read only = {29'b0, timeout, pass, done}.
  - 3 CYCLES: read only, zero-extended.
  - Writes to offsets 2/3 are acked and ignored.
- Handshake:
  - A request is accepted when o_hit=1 and no access is pending.
  - o_wb_ack pulses for exactly one cycle, ACK_DELAY cycles after acceptance.
  - The write takes effect and read data is presented in the ack cycle.
  - The next acceptance is allowed the cycle after ack; back-to-back throughput is one access per ACK_DELAY+1 cycles.
  - If cyc or stb drops while pending, the access aborts: no ack, no write.
- FSM, states IDLE, ARMED, DONE, TIMEOUT:
  - Any state + i_start -> ARMED. Clears RESULT, counter, done, pass and timeout. Any pending access is aborted.
  - ARMED: counter increments every cycle.
  - ARMED: a VALID write with data[0]=1 and sel[0]=1 -> DONE.
    - o_done=1; o_pass=(RESULT==i_expected), using RESULT after any write in the same cycle.
    - Counter freezes.
  - ARMED: counter reaches TIMEOUT-1 and increments -> TIMEOUT. o_timeout=1, counter holds TIMEOUT.
  - Same cycle VALID write and timeout: the VALID write wins (DONE).
  - DONE/TIMEOUT: sticky until i_start or reset. Bus accesses are still served. RESULT writes update the register but not o_pass.
  - IDLE: counter held at 0. RESULT writable; VALID writes acked and ignored.
  - VALID write with data[0]=0 is ignored in every state.
- Simultaneous i_start and accepted access: i_start wins; the access is dropped.
- Reset mid-access: ack never issued; on release the block is IDLE.

Test Plan:
- Reset, then i_start; write RESULT=21 (sel=4'hf), write VALID=1, i_expected=21 -> each ack 1 cycle after stb (ACK_DELAY=1); o_done=1, o_pass=1, STATUS read = 3.
- Armed, RESULT=7, expected=8, VALID=1 -> o_done=1, o_pass=0, o_timeout=0, o_cycles frozen.
- Arm, no writes -> o_timeout=1 exactly 600 cycles after i_start; o_cycles=600; later VALID write leaves o_done=0.
- Byte writes: RESULT=0, then sel=4'b0100 with data 32'h00AB0000, then sel=4'b0001 with 32'h000000CD -> RESULT read = 32'h00AB00CD.
- ACK_DELAY=3, stb dropped after 1 cycle -> no ack, RESULT unchanged. Full access -> ack on 3rd cycle; o_wb_dat=0 outside the ack cycle.
- VALID write lands on the timeout cycle -> DONE, o_timeout=0. Then i_start concurrent with a RESULT write -> ARMED, RESULT=0, no ack.
